char_write_ctrl: RTL and testbench
==================================

Name: char_write_ctrl

Overview:
Avalon-MM write-side controller that sequences character-cell updates into the Frame character buffer. The host stages X, Y, CHAR and a 24-bit COLOR byte-by-byte, then commits the staged values. Commits are queued in a small FIFO and drained to the frame buffer over a valid/ready handshake. A hardware clear-screen sequencer walks every cell. The block sits between the Avalon slave interface and Frame.

Parameters:
COLS, 40, number of character columns (max 64)
ROWS, 30, number of character rows (max 64)
DEPTH, 8, command FIFO depth (power of two, >=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
chipselect  in  1  Avalon slave select
write  in  1  Avalon write strobe
read  in  1  Avalon read strobe
address  in  3  register index
writedata  in  8  write data
readdata  out  8  status, valid one cycle after read
fb_x  out  6  cell column to Frame
fb_y  out  6  cell row to Frame
fb_char  out  5  glyph index to Frame
fb_color  out  24  RGB colour to Frame
fb_we  out  1  beat valid to Frame
fb_ready  in  1  Frame accepts beat

Behaviour:
- One clock; reset is synchronous and active-high. All outputs, staging registers, flags and FIFO pointers reset to 0; FSM resets to IDLE.
- Register writes, active when chipselect && write:
  - addr 0: X <= wd[5:0]
  - addr 1: Y <= wd[5:0]
  - addr 2: CHAR <= wd[4:0]
  - addr 3/4/5: COLOR[23:16] / [15:8] / [7:0]
  - addr 6: wd[0]=PUSH, wd[1]=CLEAR; both bits may be set in one write; CLEAR is processed first.
  - addr 7: wd[0]=1 clears the sticky OVF and RERR flags.
- PUSH:
  - If X>=COLS or Y>=ROWS: entry dropped, RERR set.
  - Else if FIFO full: entry dropped, OVF set. Fullness is evaluated before any same-cycle pop, so a push while full is dropped even when a pop occurs in that cycle.
  - Else the 41-bit entry {X,Y,CHAR,COLOR} is written to the FIFO.
- Handshake:
  - A beat transfers on a cycle with fb_we && fb_ready.
  - While fb_we=1, the fb_* data fields are held stable until transfer. fb_we is never withdrawn before transfer.
  - fb_* outputs are registered; there is no combinational path from fb_ready to fb_we.
- FSM states:
  - IDLE:
    - CLEAR pending -> CLR.
    - Else FIFO non-empty -> load head into fb_*, fb_we=1 -> SEND.
  - SEND: on transfer, pop the FIFO, then:
    - CLEAR pending -> CLR.
    - Else FIFO non-empty -> load next entry, staying in SEND. This gives 1 beat/cycle throughput when fb_ready is held high.
    - Else fb_we=0 -> IDLE.
  - CLR:
    - On entry: discard all FIFO entries pushed before the CLEAR, and zero the cell counters cx, cy.
    - Issue beats (cx, cy, char 0, colour 0) with row-major increment on each transfer: cx wraps at COLS-1 -> 0 and increments cy.
    - After the transfer of (COLS-1, ROWS-1): fb_we=0 -> IDLE.
    - Full clear takes exactly COLS*ROWS transfers.
- Ordering and simultaneous events:
  - A CLEAR arriving during SEND lets the in-flight beat complete first.
  - PUSHes accepted during CLR are retained and drained after the clear.
  - CLEAR while already in CLR is ignored.
- Status readdata, registered with latency 1 and returned for any address when chipselect && read:
  - [7] OVF
  - [6] RERR
  - [5] clearing
  - [4] FIFO full
  - [3:0] FIFO level (0..DEPTH)
- Reset asserted mid-operation: FIFO flushed, fb_we drops to 0 on the next edge, no further beats are issued.

Optional Feature:
- Macro: CHAR_WRITE_CTRL_AUTO_ADVANCE_EN.
- When defined: every accepted PUSH post-increments the staged X. If X reaches COLS it wraps to 0 and Y increments; if Y reaches ROWS it wraps to 0. Dropped pushes do not advance.
- When undefined: staging registers change only on explicit register writes.

Test Plan:
- Stage X=3, Y=5, CHAR=7, COLOR=FF0000, then PUSH with fb_ready=1 -> exactly one beat (3,5,7,FF0000); status level returns to 0.
- Hold fb_ready=0, PUSH 9 distinct entries with DEPTH=8 -> readdata = 0x98 (OVF, full, level 8); release fb_ready -> 8 beats in push order, 1/cycle.
- Stage X=40 and PUSH -> no beat, RERR=1; write addr 7 = 0x01 -> RERR and OVF read 0.
- Push 2 entries with fb_ready=0, then CLEAR, then push 1 entry, then fb_ready=1 -> the in-flight entry transfers, the other pre-clear entry is discarded, 1200 clear beats follow ending at (39,29), then the post-clear entry.
- Toggle fb_ready randomly during SEND -> fb_* data stable while fb_we=1 && !fb_ready; no lost or duplicated beats.
- Assert reset during CLR -> fb_we=0 on the next cycle, readdata=0; with AUTO_ADVANCE_EN, pushing at X=39, Y=29 stages X=0, Y=0.

Source files
------------

// File: rtl/char_write_ctrl.sv
// ---------------------------------------------------------------------------
// char_write_ctrl
//   Avalon-MM write-side controller for the Frame character buffer. The host
//   stages X, Y, CHAR and a 24-bit COLOR one byte per register write, then
//   commits them with PUSH. Commits are queued in a small FIFO and drained to
//   the frame buffer over a registered valid/ready handshake. A CLEAR command
//   walks every cell in row-major order, writing char 0 / colour 0.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   chipselect, write,  Avalon slave strobes
//   read, address,
//   writedata
//   readdata            status {OVF, RERR, clearing, full, level[3:0]},
//                       registered, valid one cycle after a read
//   fb_x, fb_y,         beat payload to Frame (registered)
//   fb_char, fb_color
//   fb_we               beat valid to Frame (registered)
//   fb_ready            Frame accepts the current beat
//
// Build option
//   CHAR_WRITE_CTRL_AUTO_ADVANCE_EN : every accepted PUSH post-increments
//   the staged X (wrapping into Y, and Y wrapping to 0).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module char_write_ctrl #(
  parameter int COLS  = 40,
  parameter int ROWS  = 30,
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [2:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  output logic [5:0]  fb_x,
  output logic [5:0]  fb_y,
  output logic [4:0]  fb_char,
  output logic [23:0] fb_color,
  output logic        fb_we,
  input  logic        fb_ready
);

  typedef enum logic [1:0] {IDLE, SEND, CLR} state_e;

  localparam int AW    = $clog2(DEPTH);
  localparam int CLAST = COLS - 1;
  localparam int RLAST = ROWS - 1;
  localparam logic [6:0]  COLS_W   = COLS[6:0];
  localparam logic [6:0]  ROWS_W   = ROWS[6:0];
  localparam logic [5:0]  COL_LAST = CLAST[5:0];
  localparam logic [5:0]  ROW_LAST = RLAST[5:0];
  localparam logic [AW:0] DEPTH_W  = DEPTH[AW:0];
  localparam logic [AW:0] PTR_ONE  = 1;

  state_e      state_q, state_d;
  logic [5:0]  x_q, x_d, y_q, y_d, cx_q, cx_d, cy_q, cy_d;
  logic [4:0]  char_q, char_d;
  logic [23:0] color_q, color_d;
  logic        ovf_q, ovf_d, rerr_q, rerr_d, clr_pend_q, clr_pend_d;
  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [AW:0] wr_q, wr_d, rd_q, rd_d, mark_q, mark_d;
  logic [5:0]  fb_x_q, fb_x_d, fb_y_q, fb_y_d;
  logic [4:0]  fb_char_q, fb_char_d;
  logic [23:0] fb_color_q, fb_color_d;
  logic        fb_we_q, fb_we_d;
  logic [7:0]  readdata_q, readdata_d;

  logic [40:0] mem [DEPTH];

  logic [AW:0] level, rd_nxt;
  logic [40:0] head, next_ent;
  logic        full, empty, xfer, reg_wr, push_cmd, clr_cmd, in_range;
  logic        push_ok, clr_req, enter_clr;

  // NOTE: every variable gets a default at the top of always_comb so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    level    = wr_q - rd_q;
    full     = (level == DEPTH_W);
    empty    = (level == '0);
    rd_nxt   = rd_q + PTR_ONE;
    head     = mem[rd_q[AW-1:0]];
    next_ent = mem[rd_nxt[AW-1:0]];
    xfer     = fb_we_q & fb_ready;

    reg_wr   = chipselect & write;
    push_cmd = reg_wr & (address == 3'd6) & writedata[0];
    // A CLEAR that arrives while already clearing is dropped outright.
    clr_cmd  = reg_wr & (address == 3'd6) & writedata[1] & (state_q != CLR);
    in_range = ({1'b0, x_q} < COLS_W) & ({1'b0, y_q} < ROWS_W);
    // Fullness is judged before any same-cycle pop.
    push_ok  = push_cmd & in_range & ~full;
    clr_req  = clr_pend_q | clr_cmd;

    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    char_d     = char_q;
    color_d    = color_q;
    ovf_d      = ovf_q;
    rerr_d     = rerr_q;
    clr_pend_d = clr_pend_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    mark_d     = mark_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    fb_x_d     = fb_x_q;
    fb_y_d     = fb_y_q;
    fb_char_d  = fb_char_q;
    fb_color_d = fb_color_q;
    fb_we_d    = fb_we_q;
    enter_clr  = 1'b0;

    readdata_d = readdata_q;
    if (chipselect && read)
      readdata_d = {ovf_q, rerr_q, (state_q == CLR) | clr_pend_q, full, 4'(level)};

    if (reg_wr) begin
      case (address)
        3'd0: x_d = writedata[5:0];
        3'd1: y_d = writedata[5:0];
        3'd2: char_d = writedata[4:0];
        3'd3: color_d[23:16] = writedata;
        3'd4: color_d[15:8] = writedata;
        3'd5: color_d[7:0] = writedata;
        3'd7: if (writedata[0]) begin
          ovf_d  = 1'b0;
          rerr_d = 1'b0;
        end
        default: ;
      endcase
    end

    if (push_cmd && !in_range) rerr_d = 1'b1;
    else if (push_cmd && full) ovf_d = 1'b1;

    if (push_ok) begin
      wr_d = wr_q + PTR_ONE;
`ifdef CHAR_WRITE_CTRL_AUTO_ADVANCE_EN
      if (({1'b0, x_q} + 7'd1) == COLS_W) begin
        x_d = '0;
        y_d = (({1'b0, y_q} + 7'd1) == ROWS_W) ? '0 : y_q + 6'd1;
      end else begin
        x_d = x_q + 6'd1;
      end
`endif
    end

    // Remember where the queue ended when CLEAR arrived; everything older is
    // discarded when the clear actually starts. A PUSH in the same write lands
    // at wr_q and is therefore kept.
    if (clr_cmd) begin
      clr_pend_d = 1'b1;
      mark_d     = wr_q;
    end

    case (state_q)
      IDLE: begin
        if (clr_req) begin
          enter_clr = 1'b1;
        end else if (!empty) begin
          {fb_x_d, fb_y_d, fb_char_d, fb_color_d} = head;
          fb_we_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          rd_d = rd_nxt;
          if (clr_req) begin
            enter_clr = 1'b1;
          end else if (level > PTR_ONE) begin
            {fb_x_d, fb_y_d, fb_char_d, fb_color_d} = next_ent;
          end else begin
            fb_we_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      CLR: begin
        if (xfer) begin
          if (cx_q == COL_LAST && cy_q == ROW_LAST) begin
            fb_we_d = 1'b0;
            state_d = IDLE;
          end else begin
            if (cx_q == COL_LAST) begin
              cx_d = '0;
              cy_d = cy_q + 6'd1;
            end else begin
              cx_d = cx_q + 6'd1;
            end
            fb_x_d = cx_d;
            fb_y_d = cy_d;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_clr) begin
      state_d    = CLR;
      clr_pend_d = 1'b0;
      rd_d       = clr_cmd ? wr_q : mark_q;
      cx_d       = '0;
      cy_d       = '0;
      fb_x_d     = '0;
      fb_y_d     = '0;
      fb_char_d  = '0;
      fb_color_d = '0;
      fb_we_d    = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before this edge, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      char_q     <= '0;
      color_q    <= '0;
      ovf_q      <= 1'b0;
      rerr_q     <= 1'b0;
      clr_pend_q <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      mark_q     <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      fb_x_q     <= '0;
      fb_y_q     <= '0;
      fb_char_q  <= '0;
      fb_color_q <= '0;
      fb_we_q    <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      char_q     <= char_d;
      color_q    <= color_d;
      ovf_q      <= ovf_d;
      rerr_q     <= rerr_d;
      clr_pend_q <= clr_pend_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      mark_q     <= mark_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      fb_x_q     <= fb_x_d;
      fb_y_q     <= fb_y_d;
      fb_char_q  <= fb_char_d;
      fb_color_q <= fb_color_d;
      fb_we_q    <= fb_we_d;
      readdata_q <= readdata_d;
    end
  end

  // NOTE: the FIFO storage is not reset; resetting the pointers is enough to
  // make stale contents unreachable, and it keeps the array mappable to RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q[AW-1:0]] <= {x_q, y_q, char_q, color_q};
  end

  assign readdata = readdata_q;
  assign fb_x     = fb_x_q;
  assign fb_y     = fb_y_q;
  assign fb_char  = fb_char_q;
  assign fb_color = fb_color_q;
  assign fb_we    = fb_we_q;

endmodule

// File: tb/tb_char_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_char_write_ctrl
//   Self-checking bench for char_write_ctrl. Expected frame-buffer beats are
//   kept in a queue built from the register-level commands issued (commit
//   order, clear sweeps, discards), and every transfer is compared against
//   the queue head. Status reads are compared against hand-derived values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_char_write_ctrl;
  localparam int COLS  = 40;
  localparam int ROWS  = 30;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset, chipselect, write, read, fb_ready;
  logic [2:0]  address;
  logic [7:0]  writedata, readdata;
  logic [5:0]  fb_x, fb_y;
  logic [4:0]  fb_char;
  logic [23:0] fb_color;
  logic        fb_we;

  char_write_ctrl #(.COLS(COLS), .ROWS(ROWS), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
    .read(read), .address(address), .writedata(writedata),
    .readdata(readdata), .fb_x(fb_x), .fb_y(fb_y), .fb_char(fb_char),
    .fb_color(fb_color), .fb_we(fb_we), .fb_ready(fb_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_clr;
    logic [40:0] ent;
  } beat_t;

  beat_t exp_q[$];
  int n_checks = 0, n_err = 0;
  int cyc = 0;
  int xfer_total = 0, fifo_xfers = 0, last_xfer_cyc = 0;
  int acc_total = 0, disc = 0;
  int sx = 0, sy = 0, sch = 0, scol = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Watches the handshake on the falling edge: a beat seen valid+ready here
  // transfers on the next rising edge.
  task automatic monitor();
    logic        prev_stall;
    logic [40:0] prev_data, cur;
    beat_t       b;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      cur = {fb_x, fb_y, fb_char, fb_color};
      if (reset !== 1'b1) begin
        if (prev_stall) begin
          check("hold_we", 64'(fb_we), 64'd1);
          check("hold_data", 64'(cur), 64'(prev_data));
        end
        if (fb_we === 1'b1 && fb_ready === 1'b1) begin
          xfer_total++;
          last_xfer_cyc = cyc;
          check("beat_was_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            b = exp_q.pop_front();
            check(b.is_clr ? "clear_beat" : "fifo_beat", 64'(cur), 64'(b.ent));
            if (!b.is_clr) fifo_xfers++;
          end
        end
        prev_stall = (fb_we === 1'b1) && (fb_ready === 1'b0);
        prev_data  = cur;
      end else begin
        prev_stall = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic rd_status(output logic [7:0] v);
    chipselect = 1'b1;
    read       = 1'b1;
    address    = 3'($urandom_range(0, 7));
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    read       = 1'b0;
    v          = readdata;
  endtask

  task automatic stage(input int x, input int y, input int ch, input int col);
    reg_wr(3'd0, 8'(x));
    reg_wr(3'd1, 8'(y));
    reg_wr(3'd2, 8'(ch));
    reg_wr(3'd3, 8'(col >> 16));
    reg_wr(3'd4, 8'(col >> 8));
    reg_wr(3'd5, 8'(col));
    sx = x & 63;
    sy = y & 63;
    sch = ch & 31;
    scol = col & 32'h00FF_FFFF;
  endtask

  // Commit the staged cell; append it to the expected stream when the
  // model says it is accepted (in range and the queue is not full).
  task automatic push_and_expect();
    int    lvl;
    logic  acc;
    beat_t b;
    lvl = acc_total - fifo_xfers - disc;
    b.is_clr = 1'b0;
    b.ent    = {6'(sx), 6'(sy), 5'(sch), 24'(scol)};
    acc = (sx < COLS) && (sy < ROWS) && (lvl < DEPTH);
    reg_wr(3'd6, 8'h01);
    if (acc) begin
      acc_total++;
      exp_q.push_back(b);
`ifdef CHAR_WRITE_CTRL_AUTO_ADVANCE_EN
      sx = sx + 1;
      if (sx == COLS) begin
        sx = 0;
        sy = (sy + 1 == ROWS) ? 0 : sy + 1;
      end
`endif
    end
  endtask

  task automatic add_clears();
    beat_t b;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        b.is_clr = 1'b1;
        b.ent    = {6'(x), 6'(y), 5'd0, 24'd0};
        exp_q.push_back(b);
      end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drained", 64'(exp_q.size()), 64'd0);
    idle(4);
  endtask

  initial begin
    logic [7:0] st;
    int x0, c0, r, v, sh;

    fork
      monitor();
    join_none

    chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = '0; writedata = '0; fb_ready = 1'b0; reset = 1'b1;
    idle(3);
    check("rst_fb_we", 64'(fb_we), 64'd0);
    check("rst_readdata", 64'(readdata), 64'd0);
    check("rst_fb_data", 64'({fb_x, fb_y, fb_char, fb_color}), 64'd0);
    reset = 1'b0;
    idle(1);
    rd_status(st);
    check("status_after_reset", 64'(st), 64'h00);

    // Single commit.
    fb_ready = 1'b1;
    x0 = xfer_total;
    stage(3, 5, 7, 32'hFF0000);
    push_and_expect();
    wait_drain(50);
    check("single_beat_count", 64'(xfer_total - x0), 64'd1);
    rd_status(st);
    check("single_status", 64'(st), 64'h00);

    // Overflow: nine commits into an 8-deep queue while Frame stalls.
    fb_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      stage(i, i + 1, i + 2, i * 4099 + 17);
      push_and_expect();
    end
    rd_status(st);
    check("ovf_status", 64'(st), 64'h98);
    c0 = cyc;
    x0 = xfer_total;
    fb_ready = 1'b1;
    wait_drain(50);
    check("ovf_beat_count", 64'(xfer_total - x0), 64'd8);
    check("ovf_back_to_back", 64'(last_xfer_cyc - c0), 64'd7);
    reg_wr(3'd7, 8'h01);
    rd_status(st);
    check("ovf_flag_cleared", 64'(st), 64'h00);

    // Out-of-range commits are dropped and flagged.
    x0 = xfer_total;
    stage(40, 0, 1, 1);
    push_and_expect();
    stage(0, 30, 1, 1);
    push_and_expect();
    idle(8);
    check("range_no_beat", 64'(xfer_total - x0), 64'd0);
    rd_status(st);
    check("range_status", 64'(st), 64'h40);
    reg_wr(3'd7, 8'h01);
    rd_status(st);
    check("range_flag_cleared", 64'(st), 64'h00);

    // CLEAR behind an in-flight beat: A in flight, B discarded, C kept,
    // D pushed mid-clear kept, a second CLEAR mid-clear ignored.
    fb_ready = 1'b0;
    stage(1, 2, 3, 32'h123456);
    push_and_expect();
    idle(3);
    stage(4, 5, 6, 32'h654321);
    push_and_expect();
    reg_wr(3'd6, 8'h02);
    void'(exp_q.pop_back());
    disc++;
    add_clears();
    stage(7, 8, 9, 32'hABCDEF);
    push_and_expect();
    fb_ready = 1'b1;
    idle(50);
    rd_status(st);
    check("clearing_status", 64'(st), 64'h21);
    stage(10, 11, 12, 32'h0F0F0F);
    push_and_expect();
    reg_wr(3'd6, 8'h02);
    wait_drain(3000);

    // Random staging/commits with Frame randomly stalling.
    for (int i = 0; i < 400; i++) begin
      fb_ready = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 6);
      case (r)
        0: begin v = $urandom_range(0, COLS - 1); reg_wr(3'd0, 8'(v)); sx = v; end
        1: begin v = $urandom_range(0, ROWS - 1); reg_wr(3'd1, 8'(v)); sy = v; end
        2: begin v = $urandom_range(0, 31); reg_wr(3'd2, 8'(v)); sch = v; end
        3, 4: begin
          v  = $urandom_range(0, 255);
          sh = $urandom_range(0, 2);
          reg_wr(3'(5 - sh), 8'(v));
          scol = (scol & ~(255 << (8 * sh))) | (v << (8 * sh));
        end
        default: begin
          if (acc_total - fifo_xfers - disc < DEPTH) push_and_expect();
          else idle(1);
        end
      endcase
    end
    fb_ready = 1'b1;
    wait_drain(200);

    // Corner cells: with auto-advance the model wraps X into Y and Y to 0.
    stage(39, 29, 1, 32'h00FF00);
    push_and_expect();
    push_and_expect();
    stage(39, 3, 2, 32'h0000FF);
    push_and_expect();
    push_and_expect();
    wait_drain(50);

    // Reset in the middle of a clear sweep.
    reg_wr(3'd6, 8'h02);
    add_clears();
    idle(100);
    rd_status(st);
    check("pre_reset_status", 64'(st), 64'h20);
    reset = 1'b1;
    idle(1);
    check("reset_mid_clear_we", 64'(fb_we), 64'd0);
    check("reset_mid_clear_readdata", 64'(readdata), 64'd0);
    exp_q.delete();
    disc = acc_total - fifo_xfers;
    sx = 0; sy = 0; sch = 0; scol = 0;
    reset = 1'b0;
    x0 = xfer_total;
    idle(20);
    check("no_beats_after_reset", 64'(xfer_total - x0), 64'd0);
    rd_status(st);
    check("status_after_mid_reset", 64'(st), 64'h00);

    // Recovery after reset.
    stage(5, 6, 7, 32'h010203);
    push_and_expect();
    wait_drain(50);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
